// File: rtl/pwr_pkg.sv
// Width helpers and pipeline constants shared by the power detector blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwr_pkg;

    // Input sample to output pulse latency in clocks
    localparam int PWR_LAT = 3;

    // Width of one unsigned square of a signed w-bit sample
    function automatic int sq_w(input int w);
        return 2 * w - 1;
    endfunction

    // Width of the sum of n squares
    function automatic int sum_w(input int w, input int n);
        return sq_w(w) + $clog2(n);
    endfunction

    // Width of the window accumulator (2**l beats of n squares)
    function automatic int acc_w(input int w, input int n, input int l);
        return sum_w(w, n) + l;
    endfunction

endpackage

// File: rtl/signed_square.sv
// Registered square of one two's-complement sample, result unsigned.
// Latency: 1 clock.
// Backpressure: none; a new sample is accepted every clock.
module signed_square
    import pwr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WIDTH-1:0]         in_i,
    output logic [sq_w(WIDTH)-1:0]   out_o
);

    localparam int SQ_W = sq_w(WIDTH);

    logic signed [2*WIDTH-1:0] prod;

    // Full-width signed product; the top bit is always zero for a square
    always_comb begin
        prod = $signed(in_i) * $signed(in_i);
    end

    // Register the square; the most negative input squared still fits SQ_W bits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_o <= '0;
        end else begin
            out_o <= SQ_W'(prod);
        end
    end

endmodule

// File: rtl/signed_square_accum.sv
// Multi-channel power detector: squares NCH samples, sums them, accumulates over 2**LOG2_WIN valid beats.
// Latency: 3 clocks from the last beat of a window to the pwr_valid_o pulse.
// Backpressure: none; full rate, valid_i gaps are skipped, clear_i drops the window and in-flight beats.
module signed_square_accum
    import pwr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NCH      = 8,
    parameter int LOG2_WIN = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NCH*WIDTH-1:0]                 in_i,
    input  logic                                 valid_i,
    input  logic                                 clear_i,
    input  logic [acc_w(WIDTH,NCH,LOG2_WIN)-1:0] thresh_i,
    output logic [acc_w(WIDTH,NCH,LOG2_WIN)-1:0] pwr_o,
    output logic                                 pwr_valid_o,
    output logic                                 over_o
);

    localparam int SQ_W  = sq_w(WIDTH);
    localparam int SUM_W = sum_w(WIDTH, NCH);
    localparam int ACC_W = acc_w(WIDTH, NCH, LOG2_WIN);
    localparam int WIN   = 1 << LOG2_WIN;
    localparam int CNT_W = (LOG2_WIN > 0) ? LOG2_WIN : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN - 1);

    logic [SQ_W-1:0]  sq [NCH];
    logic             v1;
    logic [SUM_W-1:0] sum_c;
    logic [SUM_W-1:0] sum_q;
    logic             v2;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;

    // Stage 1: one registered squarer per channel
    for (genvar c = 0; c < NCH; c++) begin : g_sq
        signed_square #(.WIDTH(WIDTH)) u_sq (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .in_i  (in_i[c*WIDTH +: WIDTH]),
            .out_o (sq[c])
        );
    end

    // Stage 1 qualifier; a beat presented together with clear is dropped here
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            v1 <= 1'b0;
        end else begin
            v1 <= valid_i;
        end
    end

    // Channel sum, widened so no carry is lost
    always_comb begin
        sum_c = '0;
        for (int c = 0; c < NCH; c++) begin
            sum_c = sum_c + SUM_W'(sq[c]);
        end
    end

    // Stage 2: register the channel sum and its qualifier
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
            v2    <= 1'b0;
        end else begin
            sum_q <= sum_c;
            v2    <= clear_i ? 1'b0 : v1;
        end
    end

    // Running total including the beat currently in stage 2
    always_comb begin
        acc_next = acc + ACC_W'(sum_q);
    end

    // Stage 3: accumulate, close the window on its last beat, clear wins over close
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc         <= '0;
            cnt         <= '0;
            pwr_o       <= '0;
            over_o      <= 1'b0;
            pwr_valid_o <= 1'b0;
        end else begin
            pwr_valid_o <= 1'b0;
            if (clear_i) begin
                acc <= '0;
                cnt <= '0;
            end else if (v2) begin
                if (cnt == LAST) begin
                    pwr_o       <= acc_next;
                    over_o      <= (acc_next >= thresh_i);
                    pwr_valid_o <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_signed_square_accum.sv
// Directed bench for signed_square_accum: default build plus a single-channel, one-beat-window build.
// Latency: checks the 3-clock beat-to-pulse delay.
// Backpressure: exercises valid gaps, clear and reset mid-window.
module tb_signed_square_accum;
    import pwr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_dat;
    logic        valid;
    logic        clear;
    logic [21:0] thresh;
    logic [21:0] pwr;
    logic        pwr_valid;
    logic        over;

    logic [7:0]  in1;
    logic        valid1;
    logic [14:0] thresh1;
    logic [14:0] pwr1;
    logic        pwr_valid1;
    logic        over1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int          pq [$];
    bit          oq [$];
    int          cq [$];

    typedef struct packed {
        logic [63:0] dat;
        logic [21:0] thr;
        logic [21:0] exp_pwr;
        logic        exp_over;
    } vec_t;

    vec_t        tbl [7];
    logic [63:0] rdat [320];
    int          rexp [20];

    always #5 clk = ~clk;

    signed_square_accum #(.WIDTH(8), .NCH(8), .LOG2_WIN(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_i        (in_dat),
        .valid_i     (valid),
        .clear_i     (clear),
        .thresh_i    (thresh),
        .pwr_o       (pwr),
        .pwr_valid_o (pwr_valid),
        .over_o      (over)
    );

    signed_square_accum #(.WIDTH(8), .NCH(1), .LOG2_WIN(0)) dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_i        (in1),
        .valid_i     (valid1),
        .clear_i     (1'b0),
        .thresh_i    (thresh1),
        .pwr_o       (pwr1),
        .pwr_valid_o (pwr_valid1),
        .over_o      (over1)
    );

    // Record every pulse of the main instance with its cycle stamp
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pwr_valid) begin
            pq.push_back(int'(pwr));
            oq.push_back(over);
            cq.push_back(cyc);
        end
    end

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d,
                                       input int e, input int f, input int g, input int h);
        return {8'(h), 8'(g), 8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic int sqsum(input logic [63:0] d);
        int s = 0;
        for (int c = 0; c < 8; c++) begin
            logic signed [7:0] b;
            int v;
            b = d[c*8 +: 8];
            v = b;
            s = s + v * v;
        end
        return s;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic v, input logic c);
        @(negedge clk);
        in_dat = d;
        valid  = v;
        clear  = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive($urandom, 1'b0, 1'b0);
    endtask

    task automatic flush_q();
        pq.delete();
        oq.delete();
        cq.delete();
    endtask

    initial begin
        int held;

        rst = 1'b1; in_dat = '0; valid = 0; clear = 0; thresh = '0;
        in1 = '0; valid1 = 0; thresh1 = 15'd16384;
        tbl[0] = '{pk(-128,-128,-128,-128,-128,-128,-128,-128), 22'd2097152, 22'd2097152, 1'b1};
        tbl[1] = '{pk(-128,-128,-128,-128,-128,-128,-128,-128), 22'd2097153, 22'd2097152, 1'b0};
        tbl[2] = '{pk(1,1,1,1,1,1,1,1),                         22'd128,     22'd128,     1'b1};
        tbl[3] = '{pk(1,2,3,4,5,6,7,8),                         22'd4000,    22'd3264,    1'b0};
        tbl[4] = '{pk(-128,127,0,0,0,0,0,0),                    22'd520209,  22'd520208,  1'b0};
        tbl[5] = '{pk(-5,5,-5,5,-5,5,-5,5),                     22'd0,       22'd3200,    1'b1};
        tbl[6] = '{pk(127,127,127,127,127,127,127,127),         22'd2064512, 22'd2064512, 1'b1};

        // Reset state
        idle(2);
        check("rst_pwr", pwr, 0);
        check("rst_vld", pwr_valid, 0);
        check("rst_over", over, 0);
        check("rst_vld1", pwr_valid1, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table: one full window per record, exact pulse timing
        for (int r = 0; r < 7; r++) begin
            thresh = tbl[r].thr;
            for (int b = 0; b < 16; b++) drive(tbl[r].dat, 1'b1, 1'b0);
            idle(1); check($sformatf("t%0d_early1", r), pwr_valid, 0);
            idle(1); check($sformatf("t%0d_early2", r), pwr_valid, 0);
            idle(1); check($sformatf("t%0d_pulse", r), pwr_valid, 1);
            check($sformatf("t%0d_pwr", r), pwr, tbl[r].exp_pwr);
            check($sformatf("t%0d_over", r), over, tbl[r].exp_over);
            idle(1); check($sformatf("t%0d_single", r), pwr_valid, 0);
            check($sformatf("t%0d_hold", r), pwr, tbl[r].exp_pwr);
        end

        // Random data, continuous valid, 20 back-to-back windows
        thresh = 22'd700000;
        for (int w = 0; w < 20; w++) begin
            rexp[w] = 0;
            for (int b = 0; b < 16; b++) begin
                rdat[w*16+b] = {$urandom, $urandom};
                rexp[w] = rexp[w] + sqsum(rdat[w*16+b]);
            end
        end
        idle(2);
        flush_q();
        for (int i = 0; i < 320; i++) drive(rdat[i], 1'b1, 1'b0);
        idle(5);
        check("rand_cnt", pq.size(), 20);
        for (int w = 0; w < 20 && w < pq.size(); w++) begin
            check($sformatf("rand_pwr%0d", w), pq[w], rexp[w]);
            check($sformatf("rand_over%0d", w), oq[w], (rexp[w] >= 700000) ? 1 : 0);
            if (w > 0) check($sformatf("rand_gap%0d", w), cq[w] - cq[w-1], 16);
        end

        // Same data with valid toggling 1010...; low beats carry junk
        flush_q();
        for (int i = 0; i < 320; i++) begin
            drive(rdat[i], 1'b1, 1'b0);
            drive({$urandom, $urandom}, 1'b0, 1'b0);
        end
        idle(5);
        check("gap_cnt", pq.size(), 20);
        for (int w = 0; w < 20 && w < pq.size(); w++) begin
            check($sformatf("gap_pwr%0d", w), pq[w], rexp[w]);
            if (w > 0) check($sformatf("gap_gap%0d", w), cq[w] - cq[w-1], 32);
        end

        // Clear at beat 7 aborts the window; output held; next window of +1
        held = rexp[19];
        flush_q();
        for (int b = 0; b < 7; b++) drive(tbl[0].dat, 1'b1, 1'b0);
        drive(tbl[0].dat, 1'b1, 1'b1);
        for (int b = 0; b < 16; b++) begin
            drive(tbl[2].dat, 1'b1, 1'b0);
            if (b == 4) begin
                check("clr_hold_pwr", pwr, held);
                check("clr_no_pulse", pwr_valid, 0);
            end
        end
        idle(5);
        check("clr_cnt", pq.size(), 1);
        if (pq.size() > 0) check("clr_pwr", pq[0], 128);

        // Clear on the closing edge wins: no pulse, then a clean window of 2s
        flush_q();
        for (int b = 0; b < 16; b++) drive(tbl[0].dat, 1'b1, 1'b0);
        drive('0, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b1);
        idle(4);
        check("clrclose_cnt", pq.size(), 0);
        check("clrclose_hold", pwr, 128);
        for (int b = 0; b < 16; b++) drive(pk(2,2,2,2,2,2,2,2), 1'b1, 1'b0);
        idle(5);
        check("post_clr_cnt", pq.size(), 1);
        if (pq.size() > 0) check("post_clr_pwr", pq[0], 512);

        // Reset mid-window clears outputs; the following 16 beats form a full window
        thresh = '0;
        for (int b = 0; b < 16; b++) drive(tbl[2].dat, 1'b1, 1'b0);
        idle(4);
        check("pre_rst_over", over, 1);
        for (int b = 0; b < 5; b++) drive(pk(3,3,3,3,3,3,3,3), 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1; valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        check("mid_rst_pwr", pwr, 0);
        check("mid_rst_over", over, 0);
        check("mid_rst_vld", pwr_valid, 0);
        flush_q();
        for (int b = 0; b < 16; b++) drive(tbl[2].dat, 1'b1, 1'b0);
        idle(5);
        check("post_rst_cnt", pq.size(), 1);
        if (pq.size() > 0) check("post_rst_pwr", pq[0], 128);

        // Single channel, one-beat windows: every beat of -128 yields 16384
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            valid1 = (i < 5);
            in1    = 8'h80;
            if (i == 2 || i == 8) check($sformatf("n1_quiet%0d", i), pwr_valid1, 0);
            if (i >= 3 && i < 8) begin
                check($sformatf("n1_vld%0d", i), pwr_valid1, 1);
                check($sformatf("n1_pwr%0d", i), pwr1, 16384);
                check($sformatf("n1_over%0d", i), over1, 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
